// File: rtl/sram_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_bist_pkg                                                |
// | Description : Shared types and constants for the SRAM BIST sequencer:      |
// |               FSM state encoding, march phase codes and the default        |
// |               pattern seed.                                                |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sram_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_GAP   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Bit 0 of a phase code means "read", bit 1 means "inverted pattern".
   localparam logic [1:0] PH_W0 = 2'd0;
   localparam logic [1:0] PH_R0 = 2'd1;
   localparam logic [1:0] PH_W1 = 2'd2;
   localparam logic [1:0] PH_R1 = 2'd3;

   localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

endpackage : sram_bist_pkg
`default_nettype wire

// File: rtl/sram_bist_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_bist_addr_gen                                           |
// | Description : Address/phase counters for the BIST march. Holds the         |
// |               request address, rw and write data registers so they stay    |
// |               stable across a whole access, and produces the expected      |
// |               read value for the current address/phase.                     |
// | Ports       : clk, reset_n   - clock, async active-low reset              |
// |               clear_i        - restart at address 0, phase PH_W0          |
// |               advance_i      - step to the next address (wraps phase)     |
// |               addr_o, rw_o, wdata_o - registered request fields           |
// |               phase_o        - current march phase                         |
// |               last_o         - current address equals LAST_ADDR            |
// |               expect_o       - value a read of addr_o should return        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sram_bist_addr_gen
   import sram_bist_pkg::*;
#(
   parameter int unsigned        ADDR_W    = 18,
   parameter int unsigned        DATA_W    = 16,
   parameter logic [ADDR_W-1:0]  LAST_ADDR = 18'h3FFFF,
   parameter logic [DATA_W-1:0]  SEED      = DEFAULT_SEED
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              rw_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [1:0]        phase_o,
   output logic              last_o,
   output logic [DATA_W-1:0] expect_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        phase_q, phase_d;
   logic              rw_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] addr_cur_ext;
   logic [DATA_W-1:0] addr_nxt_ext;
   logic              last;

   // Fit the address onto the data width for pattern generation.
   generate
      if (ADDR_W >= DATA_W) begin : g_addr_trunc
         assign addr_cur_ext = addr_q[DATA_W-1:0];
         assign addr_nxt_ext = addr_d[DATA_W-1:0];
      end else begin : g_addr_zext
         assign addr_cur_ext = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
         assign addr_nxt_ext = {{(DATA_W-ADDR_W){1'b0}}, addr_d};
      end
   endgenerate

   function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] a,
                                                 input logic              invert);
      logic [DATA_W-1:0] p;
      p = a ^ SEED;
      return invert ? ~p : p;
   endfunction

   assign last = (addr_q == LAST_ADDR);

   always_comb begin
      addr_d  = addr_q;
      phase_d = phase_q;
      if (clear_i) begin
         addr_d  = '0;
         phase_d = PH_W0;
      end else if (advance_i) begin
         if (last) begin
            addr_d  = '0;
            phase_d = phase_q + 2'd1;
         end else begin
            addr_d  = addr_q + 1'b1;
         end
      end
   end

   // Request fields are loaded from the next-state view so they are already
   // valid in the first ISSUE cycle and held until the next advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         phase_q <= PH_W0;
         rw_q    <= 1'b1;
         wdata_q <= '0;
      end else if (clear_i || advance_i) begin
         addr_q  <= addr_d;
         phase_q <= phase_d;
         rw_q    <= phase_d[0];
         wdata_q <= phase_d[0] ? '0 : pattern(addr_nxt_ext, phase_d[1]);
      end
   end

   assign addr_o   = addr_q;
   assign rw_o     = rw_q;
   assign wdata_o  = wdata_q;
   assign phase_o  = phase_q;
   assign last_o   = last;
   assign expect_o = pattern(addr_cur_ext, phase_q[1]);

endmodule : sram_bist_addr_gen
`default_nettype wire

// File: rtl/sram_bist_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_bist_seq                                                |
// | Description : Built-in self-test sequencer acting as the client of the     |
// |               SRAM controller. Runs a four-pass march (W P, R P, W ~P,     |
// |               R ~P) over 0..LAST_ADDR and reports pass/fail, the first     |
// |               failing address/data and a saturating error count.           |
// | Ports       : clk, reset_n        - clock, async active-low reset          |
// |               start               - level-sampled run request              |
// |               ready, data_s2f     - controller status and read data        |
// |               mem, rw, addr, data_f2s - controller request interface       |
// |               busy, done, pass    - run status                             |
// |               fail_addr, fail_data, err_count - failure report             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sram_bist_seq
   import sram_bist_pkg::*;
#(
   parameter int unsigned        ADDR_W    = 18,
   parameter int unsigned        DATA_W    = 16,
   parameter logic [ADDR_W-1:0]  LAST_ADDR = 18'h3FFFF,
   parameter logic [DATA_W-1:0]  SEED      = DEFAULT_SEED,
   parameter int unsigned        ERR_W     = 16
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              ready,
   input  logic [DATA_W-1:0] data_s2f,
   output logic              mem,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_f2s,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [ERR_W-1:0]  err_count
);

   state_e            state_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [DATA_W-1:0] fail_data_q;
   logic [ERR_W-1:0]  err_count_q;

   logic              gen_clear;
   logic              gen_advance;
   logic [1:0]        phase;
   logic              last;
   logic [DATA_W-1:0] expect_data;
   logic              miscompare;
   logic              run_end;

   assign gen_clear   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign gen_advance = (state_q == ST_WAIT) && ready;

   sram_bist_addr_gen #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LAST_ADDR (LAST_ADDR),
      .SEED      (SEED)
   ) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (gen_clear),
      .advance_i (gen_advance),
      .addr_o    (addr),
      .rw_o      (rw),
      .wdata_o   (data_f2s),
      .phase_o   (phase),
      .last_o    (last),
      .expect_o  (expect_data)
   );

   // Only read phases (odd codes) are compared.
   assign miscompare = phase[0] && (data_s2f != expect_data);
   assign run_end    = last && (phase == PH_R1);

   // The strobe must coincide with the cycle in which ready is seen high,
   // so it is qualified directly by ready rather than delayed a cycle.
   assign mem = (state_q == ST_ISSUE) && ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         err_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_data_q <= '0;
                  err_count_q <= '0;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ready) state_q <= ST_GAP;
            end
            ST_GAP: begin
               // Controller is latching the request; its ready is not yet meaningful.
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ready) begin
                  if (miscompare) begin
                     if (err_count_q != {ERR_W{1'b1}}) err_count_q <= err_count_q + 1'b1;
                     if (err_count_q == '0) begin
                        fail_addr_q <= addr;
                        fail_data_q <= data_s2f;
                     end
                  end
                  if (run_end) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_count_q == '0) && !miscompare;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_ISSUE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign err_count = err_count_q;

endmodule : sram_bist_seq
`default_nettype wire
